egress_axis_downsizer: RTL and testbench
========================================

Name: egress_axis_downsizer

Overview:
- Downstream of ingress_ctrl: consumes its 512-bit m_axis packet stream (tdata/tkeep/tlast) read back from DDR.
- Serialises each wide beat into 64-bit lanes for the egress MAC, emitting only lanes that carry valid bytes.
- Single clock domain, one output lane per cycle at full throughput, and a packet counter for bring-up.

Parameters:
- DATA_WIDTH_IN, 512, input beat width in bits; must be an integer multiple of DATA_WIDTH_OUT.
- DATA_WIDTH_OUT, 64, output lane width in bits; must be a multiple of 8.
- RATIO, DATA_WIDTH_IN/DATA_WIDTH_OUT (8), lanes per beat; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH_IN  wide beat; byte 0 in bits [7:0].
- s_axis_tkeep  in  DATA_WIDTH_IN/8  byte-valid mask; contiguous from byte 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&&tready.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  DATA_WIDTH_OUT  output lane.
- m_axis_tkeep  out  DATA_WIDTH_OUT/8  lane byte mask.
- m_axis_tvalid  out  1  lane valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last lane of packet.
- pkt_cnt  out  32  packets emitted (count of m_axis tlast handshakes).
- err_null_beat  out  1  one-cycle pulse when a beat with tkeep==0 is dropped.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: s_axis_tready=1; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; m_axis_tkeep=0; pkt_cnt=0; err_null_beat=0.
- Internal state: holding register data_q/keep_q/last_q, valid_q, lane index idx (clog2(RATIO) bits), and last_lane_q.
- Load: on an input handshake with tkeep!=0, capture data/keep/last, set valid_q=1 and idx=0.
- last_lane_q is the highest lane index whose keep slice is nonzero. It is computed at load time from s_axis_tkeep, not from keep_q.
- Output (combinational from registers):
  - m_axis_tvalid = valid_q.
  - m_axis_tdata = data_q[idx*DATA_WIDTH_OUT +: DATA_WIDTH_OUT], with tkeep the matching keep_q slice.
  - m_axis_tlast = last_q && (idx==last_lane_q).
- Latency: first lane appears on m_axis the cycle after the input handshake.
- Advance: on an output handshake, if idx!=last_lane_q then idx++; otherwise the beat is done.
- Lanes above last_lane_q are never emitted, on any beat, including non-last beats with partial keep.
- s_axis_tready = !valid_q || (m_axis_tvalid && m_axis_tready && idx==last_lane_q).
  - Combinational path from m_axis_tready; permitted.
  - Gives zero-bubble beat-to-beat transitions.
- Simultaneous finish and load: new beat loads and idx resets to 0 in the same cycle; no idle cycle between beats or packets.
- Sustained rate: last_lane_q+1 output cycles per input beat. A full 512-bit beat takes 8 cycles; a single-lane beat takes 1 cycle.
- Null beat (accepted with tkeep==0): not loaded; valid_q unchanged; err_null_beat pulses the next cycle.
  - If it carried tlast, the packet end is lost. This is an upstream protocol violation; no tlast is fabricated.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs are held stable.
- pkt_cnt increments on each m_axis tvalid&&tready&&tlast, and wraps at 2^32-1 → 0.
- Reset mid-packet: the holding register is discarded and idx=0; the partial packet is not completed.
- tkeep is not checked for contiguity. Non-contiguous masks pass through lane-wise unchanged; last_lane_q still follows the highest nonzero lane.

Decomposition:
- Shared package (pkt_pkg): DATA_WIDTH_IN/OUT defaults, RATIO, LANE_IDX_W=$clog2(RATIO), and a function last_lane(keep) returning the highest nonzero lane.
- Sub-module: none. The datapath is one register stage plus a lane mux; keep it flat.

Test Plan:
- Single 46-byte packet, tkeep=64'h0000_3FFF_FFFF_FFFF, tlast=1, m_tready=1 → 6 lanes.
  - Lanes 0-4 have tkeep=8'hFF; lane 5 has tkeep=8'h3F with tlast=1.
  - First lane appears 1 cycle after the handshake; pkt_cnt=1.
- 400-byte packet (6 full beats + 1 beat with 16 bytes), m_tready=1 → 50 lanes back-to-back with no gaps.
  - Only lane 49 has tlast; s_axis_tready is low for 7 of every 8 cycles during full beats.
- Back-to-back 6-byte packets ×4 (tkeep=64'h3F) → 4 lanes on 4 consecutive cycles, each with tkeep=8'h3F and tlast=1; s_axis_tready is stays high throughout; pkt_cnt=4.
- m_tready toggling every cycle during a 1200-byte packet → byte-exact reassembly versus a scoreboard; outputs stable while stalled; 150 lanes; pkt_cnt increments by exactly 1.
- Null beat (tkeep=0, tvalid=1) injected between packets → no m_axis_tvalid; err_null_beat=1 for exactly 1 cycle; the following packet is unaffected.
- rst asserted for 1 cycle on lane 3 of an 8-lane beat → next cycle m_axis_tvalid=0, pkt_cnt=0, s_axis_tready=1; a fresh packet afterwards emits correctly starting at lane 0.

Source files
------------

// File: rtl/egress_axis_downsizer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pkt_pkg
//  Description : Shared widths and lane helpers for the egress downsizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_pkg;

    localparam int DATA_WIDTH_IN  = 512;
    localparam int DATA_WIDTH_OUT = 64;
    localparam int RATIO          = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int LANE_IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int KEEP_W_IN      = DATA_WIDTH_IN / 8;
    localparam int KEEP_W_OUT     = DATA_WIDTH_OUT / 8;

    // Highest lane index whose keep slice carries at least one valid byte.
    function automatic logic [LANE_IDX_W-1:0] last_lane(input logic [KEEP_W_IN-1:0] keep);
        logic [LANE_IDX_W-1:0] hi;
        hi = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (|keep[i*KEEP_W_OUT +: KEEP_W_OUT]) begin
                hi = LANE_IDX_W'(i);
            end
        end
        return hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/egress_axis_downsizer.sv
`default_nettype none
// ============================================================================
//  Module      : egress_axis_downsizer
//  Description : Serialises wide AXI-Stream beats into narrow lanes, skipping
//                lanes without valid bytes; counts emitted packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module egress_axis_downsizer
    import pkt_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = pkt_pkg::DATA_WIDTH_IN,
    parameter int DATA_WIDTH_OUT = pkt_pkg::DATA_WIDTH_OUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH_IN-1:0]    s_axis_tdata,
    input  logic [DATA_WIDTH_IN/8-1:0]  s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [DATA_WIDTH_OUT-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH_OUT/8-1:0] m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [31:0]                 pkt_cnt,
    output logic                        err_null_beat
);

    localparam int c_RATIO  = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int c_IDX_W  = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam int c_KW_IN  = DATA_WIDTH_IN / 8;
    localparam int c_KW_OUT = DATA_WIDTH_OUT / 8;

    logic [DATA_WIDTH_IN-1:0] r_data;
    logic [c_KW_IN-1:0]       r_keep;
    logic                     r_last;
    logic                     r_valid;
    logic [c_IDX_W-1:0]       r_idx;
    logic [c_IDX_W-1:0]       r_last_lane;
    logic [31:0]              r_pkt_cnt;
    logic                     r_err_null;

    logic                      w_out_hs;
    logic                      w_beat_done;
    logic                      w_in_hs;
    logic                      w_keep_any;
    logic                      w_load;
    logic [c_IDX_W-1:0]        w_new_last_lane;
    logic [DATA_WIDTH_OUT-1:0] w_lane_data;
    logic [c_KW_OUT-1:0]       w_lane_keep;

    assign w_out_hs    = r_valid && m_axis_tready;
    assign w_beat_done = w_out_hs && (r_idx == r_last_lane);
    // Ready looks through to m_axis_tready so the next beat loads on the
    // same edge the current one finishes.
    assign s_axis_tready = !r_valid || w_beat_done;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_keep_any    = |s_axis_tkeep;
    assign w_load        = w_in_hs && w_keep_any;

    always_comb begin
        w_new_last_lane = '0;
        for (int i = 0; i < c_RATIO; i++) begin
            if (|s_axis_tkeep[i*c_KW_OUT +: c_KW_OUT]) begin
                w_new_last_lane = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_lane_data = '0;
        w_lane_keep = '0;
        for (int i = 0; i < c_RATIO; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_lane_data = r_data[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
                w_lane_keep = r_keep[i*c_KW_OUT +: c_KW_OUT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_keep      <= '0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_last_lane <= '0;
            r_pkt_cnt   <= '0;
            r_err_null  <= 1'b0;
        end else begin
            r_err_null <= w_in_hs && !w_keep_any;
            if (w_load) begin
                r_data      <= s_axis_tdata;
                r_keep      <= s_axis_tkeep;
                r_last      <= s_axis_tlast;
                r_valid     <= 1'b1;
                r_idx       <= '0;
                r_last_lane <= w_new_last_lane;
            end else if (w_beat_done) begin
                r_valid <= 1'b0;
            end else if (w_out_hs) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_out_hs && m_axis_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = w_lane_data;
    assign m_axis_tkeep  = w_lane_keep;
    assign m_axis_tlast  = r_valid && r_last && (r_idx == r_last_lane);
    assign pkt_cnt       = r_pkt_cnt;
    assign err_null_beat = r_err_null;

endmodule
`default_nettype wire

// File: tb/tb_egress_axis_downsizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_egress_axis_downsizer
//  Description : Directed scoreboard bench for the egress downsizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_egress_axis_downsizer;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } lane_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [31:0]  pkt_cnt;
    logic         err_null_beat;

    egress_axis_downsizer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_cnt       (pkt_cnt),
        .err_null_beat (err_null_beat)
    );

    always #5 clk = ~clk;

    lane_t       exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lane_cnt = 0;
    int          cyc      = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    int          ready_waits = 0;
    int          err_seen = 0;
    logic [7:0]  last_keep_seen = '0;
    bit          toggle_en = 1'b0;
    bit          held_valid = 1'b0;
    logic [72:0] held = '0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && err_null_beat) err_seen++;
    end

    // Scoreboard monitor: a lane is consumed when valid&ready at the negedge
    // before the handshaking edge; stalled lanes must not change.
    always @(negedge clk) begin
        lane_t e;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid)
                chk({m_axis_tdata, m_axis_tkeep, m_axis_tlast} == held, "stall_stable",
                    {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, held);
            held_valid = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_lane", m_axis_tdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(m_axis_tdata == e.d && m_axis_tkeep == e.k && m_axis_tlast == e.l, "lane",
                        {m_axis_tdata, m_axis_tkeep, 3'b0, m_axis_tlast}, {e.d, e.k, 3'b0, e.l});
                end
                if (lane_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                last_keep_seen = m_axis_tkeep;
                lane_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) m_axis_tready = ~m_axis_tready;
        end
    end

    function automatic logic [7:0] pbyte(input int seed, input int b);
        return 8'((seed * 37) + (b * 7) + 1);
    endfunction

    task automatic push_expected(input logic [511:0] d, input logic [63:0] k, input logic l);
        lane_t e;
        int hi;
        logic [511:0] dv;
        logic [63:0]  kv;
        dv = d;
        kv = k;
        hi = -1;
        for (int i = 0; i < 8; i++) if (kv[i*8 +: 8] != 8'h00) hi = i;
        for (int i = 0; i <= hi; i++) begin
            e.d = dv[i*64 +: 64];
            e.k = kv[i*8 +: 8];
            e.l = l && (i == hi);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        int w;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            w++;
            if (w > 2000) begin
                chk(1'b0, "s_ready_timeout", w, 0);
                break;
            end
        end
        ready_waits += w;
        @(posedge clk);
        push_expected(d, k, l);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nbytes, input int seed);
        logic [511:0] d;
        logic [63:0]  k;
        int n;
        for (int off = 0; off < nbytes; off += 64) begin
            n = (nbytes - off > 64) ? 64 : nbytes - off;
            d = '0;
            k = '0;
            for (int b = 0; b < n; b++) begin
                d[b*8 +: 8] = pbyte(seed, off + b);
                k[b] = 1'b1;
            end
            send_beat(d, k, (off + 64 >= nbytes));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(n < 3000, "drain_timeout", n, 3000);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic new_test();
        lane_cnt = 0;
        ready_waits = 0;
        err_seen = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(s_axis_tready == 1'b1, "rst_s_tready", s_axis_tready, 1);
        chk(m_axis_tvalid == 1'b0, "rst_m_tvalid", m_axis_tvalid, 0);
        chk(m_axis_tlast == 1'b0, "rst_m_tlast", m_axis_tlast, 0);
        chk(m_axis_tdata == 64'd0 && m_axis_tkeep == 8'd0, "rst_m_data_keep", {m_axis_tdata, m_axis_tkeep}, 0);
        chk(pkt_cnt == 32'd0, "rst_pkt_cnt", pkt_cnt, 0);
        chk(err_null_beat == 1'b0, "rst_err", err_null_beat, 0);

        // 46-byte single-beat packet: 6 lanes, last keep 3F, one-cycle latency
        new_test();
        send_pkt(46, 1);
        chk(m_axis_tvalid == 1'b1, "latency_1cyc", m_axis_tvalid, 1);
        wait_drain();
        chk(lane_cnt == 6, "p46_lanes", lane_cnt, 6);
        chk(last_keep_seen == 8'h3F, "p46_last_keep", last_keep_seen, 8'h3F);
        chk(pkt_cnt == 32'd1, "p46_pkt_cnt", pkt_cnt, 1);

        // 400-byte packet: 50 gapless lanes, ready low 7 of 8 cycles per full beat
        new_test();
        send_pkt(400, 2);
        wait_drain();
        chk(lane_cnt == 50, "p400_lanes", lane_cnt, 50);
        chk(last_cyc - first_cyc == 49, "p400_gapless", last_cyc - first_cyc, 49);
        chk(ready_waits == 42, "p400_ready_waits", ready_waits, 42);
        chk(pkt_cnt == 32'd2, "p400_pkt_cnt", pkt_cnt, 2);

        // Four back-to-back 6-byte packets
        new_test();
        for (int p = 0; p < 4; p++) send_pkt(6, 10 + p);
        wait_drain();
        chk(lane_cnt == 4, "p6x4_lanes", lane_cnt, 4);
        chk(last_cyc - first_cyc == 3, "p6x4_consecutive", last_cyc - first_cyc, 3);
        chk(ready_waits == 0, "p6x4_ready_high", ready_waits, 0);
        chk(pkt_cnt == 32'd6, "p6x4_pkt_cnt", pkt_cnt, 6);

        // 1200-byte packet with m_axis_tready toggling every cycle
        new_test();
        toggle_en = 1'b1;
        send_pkt(1200, 3);
        wait_drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        chk(lane_cnt == 150, "p1200_lanes", lane_cnt, 150);
        chk(pkt_cnt == 32'd7, "p1200_pkt_cnt", pkt_cnt, 7);

        // Null beat between packets
        new_test();
        send_beat({8{64'hDEAD_BEEF_0000_0001}}, 64'd0, 1'b0);
        chk(err_null_beat == 1'b1, "null_err_pulse", err_null_beat, 1);
        chk(m_axis_tvalid == 1'b0, "null_no_valid", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        chk(err_null_beat == 1'b0, "null_err_clear", err_null_beat, 0);
        repeat (3) @(posedge clk);
        #1;
        chk(lane_cnt == 0, "null_no_lanes", lane_cnt, 0);
        chk(err_seen == 1, "null_err_one_cycle", err_seen, 1);
        send_pkt(6, 20);
        wait_drain();
        chk(lane_cnt == 1, "after_null_lanes", lane_cnt, 1);
        chk(pkt_cnt == 32'd8, "after_null_pkt_cnt", pkt_cnt, 8);

        // Reset while lane 3 of a full 8-lane beat is presented
        new_test();
        send_pkt(64, 30);
        n = 0;
        while (lane_cnt < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(n < 100, "rst_wait_timeout", n, 100);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk(m_axis_tvalid == 1'b0, "midrst_m_tvalid", m_axis_tvalid, 0);
        chk(pkt_cnt == 32'd0, "midrst_pkt_cnt", pkt_cnt, 0);
        chk(s_axis_tready == 1'b1, "midrst_s_tready", s_axis_tready, 1);
        chk(lane_cnt == 3, "midrst_lanes_before", lane_cnt, 3);
        new_test();
        send_pkt(46, 31);
        wait_drain();
        chk(lane_cnt == 6, "postrst_lanes", lane_cnt, 6);
        chk(pkt_cnt == 32'd1, "postrst_pkt_cnt", pkt_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, required completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
